// File: rtl/ball_motion.sv
// Ball position register, per-frame stepping FSM and registered raster overlap flags.
// Define BALL_CLAMP_EN to clamp the ball inside the visible area instead of wrapping.
module ball_motion #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned BALL_SIZE       = 8,
    parameter int unsigned SPEED           = 2,
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned SERVE_FRAMES    = 60
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [9:0] i_HCount,
    input  logic [9:0] i_VCount,
    input  logic       i_Frame_Start,
    input  logic       i_HDir,
    input  logic       i_VDir,
    input  logic       i_Serve,
    output logic [9:0] o_Ball_X,
    output logic [9:0] o_Ball_Y,
    output logic       o_HBall,
    output logic       o_VBall,
    output logic       o_Draw_Ball,
    output logic       o_Moving
);

    typedef enum logic {
        SERVE,
        MOVE
    } state_t;

    localparam logic [9:0] X_CENTRE   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CENTRE   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] STEP_LAST  = 8'(FRAMES_PER_STEP - 1);

    state_t     state, state_n;
    logic [7:0] frame_cnt, frame_cnt_n;
    logic [9:0] ball_x_n, ball_y_n;
    logic       h_hit, v_hit;

    // One axis step in 11 bits so the sums and differences never alias.
    function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic neg,
                                            input logic [10:0] active);
        logic [10:0] p;
        logic [10:0] spd;
        logic [10:0] res;
        p   = {1'b0, pos};
        spd = 11'(SPEED);
`ifdef BALL_CLAMP_EN
        if (!neg)
            res = (p + spd > active - 11'(BALL_SIZE)) ? active - 11'(BALL_SIZE) : p + spd;
        else
            res = (p < spd) ? '0 : p - spd;
`else
        if (!neg)
            res = (p + spd > active - 11'd1) ? p + spd - active : p + spd;
        else
            res = (p < spd) ? p + active - spd : p - spd;
`endif
        return 10'(res);
    endfunction

    always_comb begin
        state_n     = state;
        frame_cnt_n = frame_cnt;
        ball_x_n    = o_Ball_X;
        ball_y_n    = o_Ball_Y;
        if (i_Serve) begin
            state_n     = SERVE;
            frame_cnt_n = '0;
            ball_x_n    = X_CENTRE;
            ball_y_n    = Y_CENTRE;
        end else if (i_Frame_Start) begin
            case (state)
                SERVE: begin
                    if (frame_cnt == SERVE_LAST) begin
                        frame_cnt_n = '0;
                        state_n     = MOVE;
                    end else begin
                        frame_cnt_n = frame_cnt + 8'd1;
                    end
                end
                MOVE: begin
                    if (frame_cnt == STEP_LAST) begin
                        frame_cnt_n = '0;
                        ball_x_n    = step_pos(o_Ball_X, i_HDir, 11'(H_ACTIVE));
                        ball_y_n    = step_pos(o_Ball_Y, i_VDir, 11'(V_ACTIVE));
                    end else begin
                        frame_cnt_n = frame_cnt + 8'd1;
                    end
                end
                default: state_n = SERVE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= SERVE;
            frame_cnt <= '0;
            o_Ball_X  <= X_CENTRE;
            o_Ball_Y  <= Y_CENTRE;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_cnt_n;
            o_Ball_X  <= ball_x_n;
            o_Ball_Y  <= ball_y_n;
        end
    end

    assign o_Moving = (state == MOVE);

    // Span compare is unmasked so blanking-region overlap still reaches direction control.
    always_comb begin
        h_hit = ({1'b0, i_HCount} >= {1'b0, o_Ball_X}) &&
                ({1'b0, i_HCount} <  {1'b0, o_Ball_X} + 11'(BALL_SIZE));
        v_hit = ({1'b0, i_VCount} >= {1'b0, o_Ball_Y}) &&
                ({1'b0, i_VCount} <  {1'b0, o_Ball_Y} + 11'(BALL_SIZE));
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_HBall     <= 1'b0;
            o_VBall     <= 1'b0;
            o_Draw_Ball <= 1'b0;
        end else begin
            o_HBall     <= h_hit;
            o_VBall     <= v_hit;
            o_Draw_Ball <= h_hit && v_hit;
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: serve delay, stepping, wrap, overlap flags, serve and async reset.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       frame_start = 1'b0;
    logic       hdir = 1'b0;
    logic       vdir = 1'b0;
    logic       serve = 1'b0;

    logic [9:0] ball_x, ball_y;
    logic       hball, vball, draw_ball, moving;
    logic [9:0] ball_x3, ball_y3;
    logic       hball3, vball3, draw_ball3, moving3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ball_motion dut (
        .i_Clk(clk), .i_Reset(rst), .i_HCount(hcount), .i_VCount(vcount),
        .i_Frame_Start(frame_start), .i_HDir(hdir), .i_VDir(vdir), .i_Serve(serve),
        .o_Ball_X(ball_x), .o_Ball_Y(ball_y), .o_HBall(hball), .o_VBall(vball),
        .o_Draw_Ball(draw_ball), .o_Moving(moving)
    );

    ball_motion #(.FRAMES_PER_STEP(3), .SERVE_FRAMES(2)) dut3 (
        .i_Clk(clk), .i_Reset(rst), .i_HCount(hcount), .i_VCount(vcount),
        .i_Frame_Start(frame_start), .i_HDir(hdir), .i_VDir(vdir), .i_Serve(serve),
        .o_Ball_X(ball_x3), .o_Ball_Y(ball_y3), .o_HBall(hball3), .o_VBall(vball3),
        .o_Draw_Ball(draw_ball3), .o_Moving(moving3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic h, input logic v);
        @(negedge clk);
        hdir = h;
        vdir = v;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic raster(input logic [9:0] h, input logic [9:0] v);
        @(negedge clk);
        hcount = h;
        vcount = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_x", ball_x, 316);
        check("rst_y", ball_y, 236);
        check("rst_hball", hball, 0);
        check("rst_vball", vball, 0);
        check("rst_draw", draw_ball, 0);
        check("rst_moving", moving, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 59; i++) begin
            frame(1'b0, 1'b0);
            if (i == 1) check("fps3_moving", moving3, 1);
            if (i == 3) check("fps3_x_hold", ball_x3, 316);
            if (i == 4) begin
                check("fps3_x_step", ball_x3, 318);
                check("fps3_y_step", ball_y3, 238);
            end
        end
        check("serve59_x", ball_x, 316);
        check("serve59_y", ball_y, 236);
        check("serve59_moving", moving, 0);
        frame(1'b0, 1'b0);
        check("serve60_moving", moving, 1);
        check("serve60_x", ball_x, 316);

        frame(1'b0, 1'b0);
        check("step_dr_x", ball_x, 318);
        check("step_dr_y", ball_y, 238);
        frame(1'b1, 1'b1);
        check("step_ul_x", ball_x, 316);
        check("step_ul_y", ball_y, 236);

        for (int i = 0; i < 161; i++) frame(1'b0, logic'(i % 2));
        check("edge_x", ball_x, 638);
        check("edge_y", ball_y, 238);
        frame(1'b0, 1'b1);
        check("wrap_right_x", ball_x, 0);
        check("wrap_right_y", ball_y, 236);
        frame(1'b1, 1'b0);
        check("wrap_left_x", ball_x, 638);
        check("wrap_left_y", ball_y, 238);

        for (int i = 0; i < 93; i++) frame(1'b1, 1'b1);
        for (int i = 0; i < 176; i++) frame(1'b1, logic'(i % 2));
        check("pos_x", ball_x, 100);
        check("pos_y", ball_y, 52);

        for (int h = 99; h <= 108; h++) begin
            raster(10'(h), 10'd52);
            check($sformatf("hball_h%0d", h), hball, (h >= 100 && h < 108) ? 1 : 0);
            check($sformatf("draw_h%0d", h), draw_ball, (h >= 100 && h < 108) ? 1 : 0);
        end
        check("vball_in", vball, 1);
        raster(10'd103, 10'd59);
        check("vball_last", vball, 1);
        raster(10'd103, 10'd60);
        check("vball_below", vball, 0);
        check("draw_below", draw_ball, 0);
        check("hball_below", hball, 1);
        raster(10'd1000, 10'd52);
        check("hball_blank", hball, 0);

        @(negedge clk);
        serve = 1'b1;
        frame_start = 1'b1;
        hdir = 1'b0;
        vdir = 1'b0;
        @(negedge clk);
        serve = 1'b0;
        frame_start = 1'b0;
        check("serve_x", ball_x, 316);
        check("serve_y", ball_y, 236);
        check("serve_moving", moving, 0);
        frame(1'b0, 1'b0);
        check("serve_hold_x", ball_x, 316);

        for (int i = 0; i < 59; i++) frame(1'b0, 1'b0);
        check("reserve_moving", moving, 1);
        frame(1'b0, 1'b0);
        check("pre_rst_x", ball_x, 318);
        raster(10'd320, 10'd240);
        check("pre_rst_draw", draw_ball, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_x", ball_x, 316);
        check("arst_y", ball_y, 236);
        check("arst_hball", hball, 0);
        check("arst_vball", vball, 0);
        check("arst_draw", draw_ball, 0);
        check("arst_moving", moving, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Sits directly upstream of the direction-control stage.
- Holds the ball's X/Y position and advances it once per frame step in the direction given by i_HDir/i_VDir.
- Compares the live raster counters against the ball position and produces the registered i_HBall/i_VBall overlap flags, which direction control consumes for edge bounces.
- Also produces the combined ball-draw strobe for the pixel mux.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- BALL_SIZE, 8, ball edge length in pixels (square); 1..32.
- SPEED, 2, pixels moved per step on each axis; 1..BALL_SIZE.
- FRAMES_PER_STEP, 1, frames between position steps; 1..255.
- SERVE_FRAMES, 60, frames the ball is held at centre before moving; 1..255.

Ports:
- i_Clk  in  1  pixel clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_HCount  in  10  current raster column; 0 at first visible pixel.
- i_VCount  in  10  current raster line; 0 at first visible line.
- i_Frame_Start  in  1  one-cycle pulse at the start of each frame, during vertical blank.
- i_HDir  in  1  0 = right (+X), 1 = left (−X); from direction control.
- i_VDir  in  1  0 = down (+Y), 1 = up (−Y); from direction control.
- i_Serve  in  1  one-cycle pulse; re-centre the ball and restart the serve delay.
- o_Ball_X  out  10  left edge of ball.
- o_Ball_Y  out  10  top edge of ball.
- o_HBall  out  1  raster column inside ball span.
- o_VBall  out  1  raster line inside ball span.
- o_Draw_Ball  out  1  o_HBall AND o_VBall.
- o_Moving  out  1  high in MOVE state.

Behaviour:
- Reset (async assert; deassert takes effect on the next i_Clk rising edge):
  - o_Ball_X = (H_ACTIVE−BALL_SIZE)/2, o_Ball_Y = (V_ACTIVE−BALL_SIZE)/2.
  - o_HBall, o_VBall, o_Draw_Ball, o_Moving = 0.
  - State = SERVE; frame counter = 0.
- All logic is on the rising edge of i_Clk. Direction control samples on the falling edge, so the outputs are stable half a cycle later.
- State machine:
  - SERVE: position is held at centre. Each i_Frame_Start increments the frame counter. When the counter reaches SERVE_FRAMES−1 on an i_Frame_Start, the counter clears and the state goes to MOVE. That pulse does not step the ball.
  - MOVE: o_Moving = 1. Each i_Frame_Start increments the step counter. When the counter reaches FRAMES_PER_STEP−1, the counter clears and both axes step: X ± SPEED per i_HDir, Y ± SPEED per i_VDir. i_HDir/i_VDir are sampled in the same cycle as i_Frame_Start.
  - i_Serve in any state: position → centre, counter → 0, state → SERVE on the next edge.
  - If i_Serve and i_Frame_Start coincide, serve wins and no step occurs.
- Arithmetic is done in 11 bits, signed-safe.
- Default (no macro) wrap rules, X axis:
  - +X: if X+SPEED > H_ACTIVE−1, new X = X+SPEED−H_ACTIVE.
  - −X: if X < SPEED, new X = X+H_ACTIVE−SPEED.
  - The Y axis uses the same rules with V_ACTIVE.
- Position changes only at i_Frame_Start, never during active video.
- Overlap flags, registered, 1-cycle latency from the raster counter:
  - o_HBall = (i_HCount >= X) AND (i_HCount < X+BALL_SIZE), compared in 11 bits so X+BALL_SIZE can exceed 1023 without aliasing.
  - o_VBall uses the same rule with i_VCount and Y.
  - The flags remain valid in blanking regions (counters beyond active). This is how direction control detects the ball touching blank, so they must not be masked.
- o_Draw_Ball is registered alongside o_HBall/o_VBall, with the same latency.

Optional Feature:
- Macro: BALL_CLAMP_EN.
- Defined:
  - +X step: new X = min(X+SPEED, H_ACTIVE−BALL_SIZE).
  - −X step: new X = max(X−SPEED, 0).
  - The Y axis is clamped the same way with V_ACTIVE.
  - The ball never leaves the visible area and no wrap occurs.
- Undefined: the wrap rules in Behaviour apply.

Test Plan:
- Reset, then 59 i_Frame_Start pulses → X=316, Y=236, o_Moving=0. 60th pulse → o_Moving=1, position unchanged.
- MOVE with HDir=0, VDir=0, SPEED=2: one frame pulse → X=318, Y=238. Then HDir=1, VDir=1: one pulse → X=316, Y=236.
- FRAMES_PER_STEP=3: 3 frame pulses in MOVE → exactly one step. 2 pulses → no change.
- X=638, HDir=0, SPEED=2, no clamp → X=0 after step. With BALL_CLAMP_EN, X=630 → X=632, then stays at 632.
- Ball at X=100, Y=50: drive HCount 99..108 at VCount=50 → o_HBall high for HCount 100..107, seen one cycle late. o_Draw_Ball matches. At VCount=58, o_Draw_Ball=0.
- i_Serve coincident with i_Frame_Start in MOVE → centre position, SERVE state, no step. Async i_Reset asserted mid-line → outputs reset immediately, without waiting for a clock edge.
